// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the debug/control front end and the run controller.
// The front end (master) issues run/quit/step commands and stall requests.
// The controller (slave) returns the stall, flush and status outputs.
interface cpu_run_ctrl_if #(
  parameter int STAGES = 4,
  parameter int NSTALL = 2,
  parameter int CNT_W  = 16
);
  logic [NSTALL-1:0] stall_src;
  logic              cpu_start;
  logic              quit_cmd;
  logic              step_cmd;
  logic [CNT_W-1:0]  step_num;
  logic              stall;
  logic [STAGES-1:0] stall_dly;
  logic              stall_1shot;
  logic              stall_fin;
  logic              stall_fin2;
  logic [STAGES:0]   rst_pipe;
  logic [1:0]        run_state;
  logic              step_done;

  modport master (
    output stall_src, cpu_start, quit_cmd, step_cmd, step_num,
    input  stall, stall_dly, stall_1shot, stall_fin, stall_fin2,
           rst_pipe, run_state, step_done
  );

  modport slave (
    input  stall_src, cpu_start, quit_cmd, step_cmd, step_num,
    output stall, stall_dly, stall_1shot, stall_fin, stall_fin2,
           rst_pipe, run_state, step_done
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run/stall/pipe-reset controller.
// HALT/RUN/STEP state machine drives a global stall, a per-stage delayed
// stall chain with edge pulses, and a per-stage pipeline flush pulse chain.
// STEP retires a programmed number of unstalled cycles and then halts
// without flushing, so the pipeline state carries over to the next step.
module cpu_run_ctrl #(
  parameter int STAGES = 4,
  parameter int NSTALL = 2,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  step_cnt_q,  step_cnt_d;
  logic [STAGES-1:0] stall_dly_q, stall_dly_d;
  logic [STAGES:0]   rst_pipe_q,  rst_pipe_d;
  logic              step_done_q, step_done_d;
  logic              stall;
  logic              flush;

  // Global stall: anything but RUN/STEP holds the pipe, as does any source.
  assign stall = (state_q == ST_HALT) | (|bus.stall_src);

  // Next-state, step counter, flush trigger and completion pulse.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (bus.quit_cmd) begin
          state_d = ST_HALT;
        end else if (bus.cpu_start) begin
          state_d = ST_RUN;
          flush   = 1'b1;
        end else if (bus.step_cmd && (bus.step_num != '0)) begin
          state_d    = ST_STEP;
          step_cnt_d = bus.step_num;
          flush      = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.quit_cmd) begin
          state_d = ST_HALT;
          flush   = 1'b1;
        end
      end
      ST_STEP: begin
        if (bus.quit_cmd) begin
          state_d = ST_HALT;
          flush   = 1'b1;
        end else if (!stall) begin
          // Only unstalled cycles count; the last one halts without a flush.
          if (step_cnt_q == CNT_W'(1)) begin
            state_d     = ST_HALT;
            step_cnt_d  = '0;
            step_done_d = 1'b1;
          end else if (step_cnt_q != '0) begin
            step_cnt_d = step_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Delay chains: stall history and flush pulse, one stage per cycle.
  always_comb begin
    stall_dly_d = {stall_dly_q[STAGES-2:0], stall};
    rst_pipe_d  = {rst_pipe_q[STAGES-1:0], flush};
  end

  // All state; stall chain resets high so the pipe comes up stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      step_cnt_q  <= '0;
      stall_dly_q <= '1;
      rst_pipe_q  <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      stall_dly_q <= stall_dly_d;
      rst_pipe_q  <= rst_pipe_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.stall_dly   = stall_dly_q;
  assign bus.stall_1shot = stall & ~stall_dly_q[0];
  assign bus.stall_fin   = ~stall & stall_dly_q[0];
  assign bus.stall_fin2  = ~stall_dly_q[0] & stall_dly_q[1];
  assign bus.rst_pipe    = rst_pipe_q;
  assign bus.run_state   = state_q;
  assign bus.step_done   = step_done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a per-cycle vector table covering start,
// external stalls in RUN, quit/start collision, ignored zero step and a
// stalled single step, plus hand sequences for async reset mid-STEP.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.STAGES(4), .NSTALL(2), .CNT_W(16)) bus ();

  cpu_run_ctrl #(.STAGES(4), .NSTALL(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  src;
    logic        start;
    logic        quit;
    logic        stp;
    logic [15:0] num;
    logic        e_stall;
    logic [3:0]  e_dly;
    logic        e_1shot;
    logic        e_fin;
    logic        e_fin2;
    logic [4:0]  e_rp;
    logic [1:0]  e_rs;
    logic        e_done;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t v(logic [1:0] src, logic st, logic q, logic sp,
                             logic [15:0] num, logic s, logic [3:0] d,
                             logic o, logic f, logic f2, logic [4:0] rp,
                             logic [1:0] rs, logic dn);
    vec_t r;
    r.src = src; r.start = st; r.quit = q; r.stp = sp; r.num = num;
    r.e_stall = s; r.e_dly = d; r.e_1shot = o; r.e_fin = f; r.e_fin2 = f2;
    r.e_rp = rp; r.e_rs = rs; r.e_done = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] src, input logic st, input logic q,
                       input logic sp, input logic [15:0] num);
    bus.stall_src = src;
    bus.cpu_start = st;
    bus.quit_cmd  = q;
    bus.step_cmd  = sp;
    bus.step_num  = num;
  endtask

  task automatic chk_reset_vals(input string nm, input int idx);
    chk({nm, "_stall"}, idx, 32'(bus.stall), 32'd1);
    chk({nm, "_dly"},   idx, 32'(bus.stall_dly), 32'hF);
    chk({nm, "_1shot"}, idx, 32'(bus.stall_1shot), 32'd0);
    chk({nm, "_fin"},   idx, 32'(bus.stall_fin), 32'd0);
    chk({nm, "_fin2"},  idx, 32'(bus.stall_fin2), 32'd0);
    chk({nm, "_rp"},    idx, 32'(bus.rst_pipe), 32'd0);
    chk({nm, "_rs"},    idx, 32'(bus.run_state), 32'd0);
    chk({nm, "_done"},  idx, 32'(bus.step_done), 32'd0);
  endtask

  initial begin
    // src st q sp num | stall dly 1shot fin fin2 rst_pipe run_state done
    vecs[0]  = v(2'b00,0,0,0,16'd0, 1,4'b1111,0,0,0,5'b00000,2'b00,0);
    vecs[1]  = v(2'b00,1,0,0,16'd0, 1,4'b1111,0,0,0,5'b00000,2'b00,0);
    vecs[2]  = v(2'b00,0,0,0,16'd0, 0,4'b1111,0,1,0,5'b00001,2'b01,0);
    vecs[3]  = v(2'b00,0,0,0,16'd0, 0,4'b1110,0,0,1,5'b00010,2'b01,0);
    vecs[4]  = v(2'b00,0,0,0,16'd0, 0,4'b1100,0,0,0,5'b00100,2'b01,0);
    vecs[5]  = v(2'b00,0,0,0,16'd0, 0,4'b1000,0,0,0,5'b01000,2'b01,0);
    vecs[6]  = v(2'b00,0,0,0,16'd0, 0,4'b0000,0,0,0,5'b10000,2'b01,0);
    vecs[7]  = v(2'b10,1,0,0,16'd0, 1,4'b0000,1,0,0,5'b00000,2'b01,0);
    vecs[8]  = v(2'b10,0,0,1,16'd3, 1,4'b0001,0,0,0,5'b00000,2'b01,0);
    vecs[9]  = v(2'b10,0,0,0,16'd0, 1,4'b0011,0,0,0,5'b00000,2'b01,0);
    vecs[10] = v(2'b00,0,0,0,16'd0, 0,4'b0111,0,1,0,5'b00000,2'b01,0);
    vecs[11] = v(2'b00,0,0,0,16'd0, 0,4'b1110,0,0,1,5'b00000,2'b01,0);
    vecs[12] = v(2'b00,1,1,0,16'd0, 0,4'b1100,0,0,0,5'b00000,2'b01,0);
    vecs[13] = v(2'b00,0,0,0,16'd0, 1,4'b1000,1,0,0,5'b00001,2'b00,0);
    vecs[14] = v(2'b00,0,0,1,16'd0, 1,4'b0001,0,0,0,5'b00010,2'b00,0);
    vecs[15] = v(2'b00,0,0,0,16'd0, 1,4'b0011,0,0,0,5'b00100,2'b00,0);
    vecs[16] = v(2'b00,0,0,0,16'd0, 1,4'b0111,0,0,0,5'b01000,2'b00,0);
    vecs[17] = v(2'b00,0,0,0,16'd0, 1,4'b1111,0,0,0,5'b10000,2'b00,0);
    vecs[18] = v(2'b00,0,0,1,16'd5, 1,4'b1111,0,0,0,5'b00000,2'b00,0);
    vecs[19] = v(2'b00,0,0,0,16'd0, 0,4'b1111,0,1,0,5'b00001,2'b10,0);
    vecs[20] = v(2'b00,1,0,0,16'd0, 0,4'b1110,0,0,1,5'b00010,2'b10,0);
    vecs[21] = v(2'b01,0,0,0,16'd0, 1,4'b1100,1,0,0,5'b00100,2'b10,0);
    vecs[22] = v(2'b01,0,0,0,16'd0, 1,4'b1001,0,0,0,5'b01000,2'b10,0);
    vecs[23] = v(2'b00,0,0,1,16'd9, 0,4'b0011,0,1,0,5'b10000,2'b10,0);
    vecs[24] = v(2'b00,0,0,0,16'd0, 0,4'b0110,0,0,1,5'b00000,2'b10,0);
    vecs[25] = v(2'b00,0,0,0,16'd0, 0,4'b1100,0,0,0,5'b00000,2'b10,0);
    vecs[26] = v(2'b00,0,0,0,16'd0, 1,4'b1000,1,0,0,5'b00000,2'b00,1);
    vecs[27] = v(2'b00,0,0,0,16'd0, 1,4'b0001,0,0,0,5'b00000,2'b00,0);

    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: pipe held stalled, no flush, HALT.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_stall", c, 32'(bus.stall), 32'd1);
      chk("idle_dly",   c, 32'(bus.stall_dly), 32'hF);
      chk("idle_rp",    c, 32'(bus.rst_pipe), 32'd0);
      chk("idle_rs",    c, 32'(bus.run_state), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].src, vecs[i].start, vecs[i].quit, vecs[i].stp, vecs[i].num);
      @(negedge clk);
      chk("stall", i, 32'(bus.stall),       32'(vecs[i].e_stall));
      chk("dly",   i, 32'(bus.stall_dly),   32'(vecs[i].e_dly));
      chk("1shot", i, 32'(bus.stall_1shot), 32'(vecs[i].e_1shot));
      chk("fin",   i, 32'(bus.stall_fin),   32'(vecs[i].e_fin));
      chk("fin2",  i, 32'(bus.stall_fin2),  32'(vecs[i].e_fin2));
      chk("rp",    i, 32'(bus.rst_pipe),    32'(vecs[i].e_rp));
      chk("rs",    i, 32'(bus.run_state),   32'(vecs[i].e_rs));
      chk("done",  i, 32'(bus.step_done),   32'(vecs[i].e_done));
      @(posedge clk); #1;
    end
    drive(2'b00, 0, 0, 0, 16'd0);
    repeat (2) @(posedge clk); #1;

    // Step of 5, then async reset once step_cnt has reached 3.
    drive(2'b00, 0, 0, 1, 16'd5);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 16'd0);
    @(negedge clk);
    chk("rstep_rs", 0, 32'(bus.run_state), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstep_rs", 1, 32'(bus.run_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst", 0);
    @(negedge clk);
    chk_reset_vals("midrst", 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh step of 2: exactly two unstalled STEP cycles, then done.
    drive(2'b00, 0, 0, 1, 16'd2);
    @(negedge clk);
    chk("s2_rs", 0, 32'(bus.run_state), 32'd0);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 16'd0);
    @(negedge clk);
    chk("s2_rs",    1, 32'(bus.run_state), 32'd2);
    chk("s2_stall", 1, 32'(bus.stall), 32'd0);
    chk("s2_rp",    1, 32'(bus.rst_pipe), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s2_rs",    2, 32'(bus.run_state), 32'd2);
    chk("s2_stall", 2, 32'(bus.stall), 32'd0);
    chk("s2_done",  2, 32'(bus.step_done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s2_rs",    3, 32'(bus.run_state), 32'd0);
    chk("s2_stall", 3, 32'(bus.stall), 32'd1);
    chk("s2_done",  3, 32'(bus.step_done), 32'd1);
    chk("s2_rp0",   3, 32'(bus.rst_pipe[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s2_done",  4, 32'(bus.step_done), 32'd0);
    chk("s2_rs",    4, 32'(bus.run_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised CPU run/stall/pipe-reset controller.
- Successor to the fixed 4-stage status block: configurable stage count, N ORed stall sources, and a single-step mode that retires a programmed number of unstalled cycles then halts.
- Sits between the debug/control front end (start/quit/step commands) and the CPU pipeline.
- Drives the global stall, per-stage delayed stalls, stall edge pulses and per-stage pipeline reset pulses.

Parameters:
- STAGES, 4: number of delayed pipeline stages after fetch/decode (e.g. EX, MA, WB, plus one). Legal range 2..8.
- NSTALL, 2: number of external stall sources (e.g. D$, I$). Legal range 1..8.
- CNT_W, 16: width of the step count.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- stall_src  input  NSTALL  external stall requests, any bit high stalls
- cpu_start  input  1  enter RUN (level or pulse)
- quit_cmd  input  1  return to HALT
- step_cmd  input  1  single-cycle pulse, enter STEP
- step_num  input  CNT_W  unstalled cycles to execute in STEP, sampled with step_cmd
- stall  output  1  combinational global stall
- stall_dly  output  STAGES  stall_dly[0] = stall delayed 1 cycle; stall_dly[i] = stall_dly[i-1] delayed 1 cycle
- stall_1shot  output  1  stall rising edge
- stall_fin  output  1  stall falling edge
- stall_fin2  output  1  falling edge of stall_dly[0]
- rst_pipe  output  STAGES+1  rst_pipe[0] registered flush pulse; rst_pipe[i] = rst_pipe[i-1] delayed 1 cycle
- run_state  output  2  00 HALT, 01 RUN, 10 STEP
- step_done  output  1  registered 1-cycle pulse when STEP completes

Behaviour:
- State machine, priority quit > start > step:
  - HALT: quit_cmd → stay HALT. Else cpu_start → RUN. Else step_cmd with step_num != 0 → STEP, loading step_cnt = step_num. step_cmd with step_num == 0 is ignored.
  - RUN: quit_cmd → HALT. cpu_start and step_cmd are ignored.
  - STEP: quit_cmd → HALT (no step_done). A cycle with stall == 0 decrements step_cnt. When step_cnt == 1 and stall == 0, go to HALT and raise step_done next cycle. cpu_start and step_cmd are ignored.
- running = (state != HALT). stall = ~running | (|stall_src), purely combinational, with no added latency.
- A stall_src bit asserted in STEP freezes step_cnt; the step completes only after exactly step_num unstalled cycles.
- stall_dly: shift chain. stall_1shot = stall & ~stall_dly[0]. stall_fin = ~stall & stall_dly[0]. stall_fin2 = ~stall_dly[0] & stall_dly[1].
- Flush pulse: rst_pipe[0] registered high for one cycle after any HALT→RUN, HALT→STEP or quit-driven RUN/STEP→HALT transition. No flush on normal step completion, so pipeline state is preserved for the next step.
- rst_pipe[k] asserts exactly k+1 cycles after the triggering edge. A new trigger while earlier pulses are in flight simply shifts in; no merging or suppression.
- step_cnt: unsigned CNT_W; never wraps; holds its value in HALT/RUN.
- Reset (async, also mid-operation):
  - state HALT, step_cnt 0.
  - stall_dly all 1, so stall = 1 and stall_1shot = 0.
  - rst_pipe all 0, step_done 0.
  - Because stall_dly[0] = 1 and stall = 1 at reset, stall_fin = 0; because stall_dly[0] = stall_dly[1] = 1, stall_fin2 = 0.
  - run_state 00.

Test Plan:
- Reset release, no commands → stall=1, stall_dly=4'b1111, rst_pipe=0, run_state=00 for 20 cycles.
- cpu_start pulse at cycle 10, stall_src=0 → stall=0 at cycle 11. rst_pipe[0] high at cycle 11 only, rst_pipe[4] at cycle 15. stall_fin high at cycle 11, stall_fin2 at cycle 12, stall_dly[3] falls at cycle 15.
- RUN, stall_src=2'b10 for 3 cycles → stall high 3 cycles, stall_1shot one cycle at onset, stall_fin one cycle after release. No rst_pipe pulse; run_state stays 01.
- From HALT, step_cmd with step_num=5, stall_src[0] high for 2 cycles mid-step → exactly 5 cycles with stall=0 (7 cycles in STEP). Returns to HALT, step_done pulses once, no end flush.
- quit_cmd and cpu_start asserted together in RUN → HALT, single rst_pipe[0] pulse. step_cmd with step_num=0 in HALT → no state change.
- rst_n asserted mid-STEP (step_cnt=3) → immediate HALT, all outputs at reset values. A later step_cmd with step_num=2 runs exactly 2 unstalled cycles.
